// File: rtl/buslayer_pkg.sv
// Shared types for the bus-layer arbiter: FSM state encoding, the latched
// transfer descriptor and the default requester count.
package buslayer_pkg;

    localparam int NUM_REQ_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    // Fields of the winning request, frozen for the whole bus transfer.
    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  sel;
    } xfer_hold_t;

    function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/buslayer_arbiter_if.sv
// Requester-side and bus-master-side signals of the arbiter. The master
// modport is the arbiter's view; slave is the surrounding system's view.
interface buslayer_arbiter_if
    import buslayer_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
);

    logic [NUM_REQ-1:0]       req_request;
    logic [NUM_REQ-1:0]       req_write;
    logic [NUM_REQ-1:0][31:0] req_address;
    logic [NUM_REQ-1:0][31:0] req_data;
    logic [NUM_REQ-1:0][3:0]  req_sel;
    logic [NUM_REQ-1:0]       req_grant;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       req_error;
    logic [31:0]              req_rdata;

    logic                     m_request;
    logic                     m_write;
    logic [31:0]              m_address;
    logic [31:0]              m_data;
    logic [3:0]               m_sel;
    logic                     m_busy;
    logic                     m_ready;
    logic                     m_error;
    logic [31:0]              m_rdata;

    modport master (
        input  req_request, req_write, req_address, req_data, req_sel,
        input  m_busy, m_ready, m_error, m_rdata,
        output req_grant, req_ready, req_error, req_rdata,
        output m_request, m_write, m_address, m_data, m_sel
    );

    modport slave (
        output req_request, req_write, req_address, req_data, req_sel,
        output m_busy, m_ready, m_error, m_rdata,
        input  req_grant, req_ready, req_error, req_rdata,
        input  m_request, m_write, m_address, m_data, m_sel
    );

endinterface

// File: rtl/buslayer_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import buslayer_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEFAULT,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [IW-1:0]      index
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every combinational output and temporary gets a default before
        // any conditional assignment, so no path can infer a latch.
        valid = 1'b0;
        index = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            cand = sum[IW-1:0];
            if (!valid && request[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/buslayer_arbiter.sv
// Round-robin arbiter sharing one bus-master port among NUM_REQ requesters;
// one transfer at a time, with retry while the master refuses.
module buslayer_arbiter
    import buslayer_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEFAULT,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    buslayer_arbiter_if.master bus
);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      winner_q, winner_d;
    xfer_hold_t         hold_q, hold_d;
    logic               m_request_q, m_request_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] error_q, error_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               pick_valid;
    logic [IW-1:0]      pick_index;
    logic [NUM_REQ-1:0] winner_onehot;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .request (bus.req_request),
        .ptr     (ptr_q),
        .valid   (pick_valid),
        .index   (pick_index)
    );

    assign winner_onehot = NUM_REQ'(1) << winner_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        hold_d      = hold_q;
        grant_d     = grant_q;
        m_request_d = 1'b0;
        ready_d     = '0;
        error_d     = '0;
        rdata_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                // A busy master (e.g. still in its own reset) blocks issue.
                if (pick_valid && !bus.m_busy) begin
                    state_d        = ST_ISSUE;
                    winner_d       = pick_index;
                    hold_d.write   = bus.req_write[pick_index];
                    hold_d.address = bus.req_address[pick_index];
                    hold_d.data    = bus.req_data[pick_index];
                    hold_d.sel     = bus.req_sel[pick_index];
                    grant_d        = NUM_REQ'(1) << pick_index;
                    m_request_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Master refused the request: reissue the same held transfer.
                if (bus.m_busy) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d     = ST_ISSUE;
                    m_request_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.m_ready || bus.m_error) begin
                    state_d = ST_RESP;
                    ready_d = bus.m_ready ? winner_onehot : '0;
                    error_d = bus.m_error ? winner_onehot : '0;
                    rdata_d = bus.m_rdata;
                    ptr_d   = IW'(next_index(32'(winner_q), NUM_REQ));
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                winner_d = '0;
                hold_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (wb_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            hold_q      <= '0;
            m_request_q <= 1'b0;
            grant_q     <= '0;
            ready_q     <= '0;
            error_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            hold_q      <= hold_d;
            m_request_q <= m_request_d;
            grant_q     <= grant_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            rdata_q     <= rdata_d;
        end
    end

    // Hold registers are cleared on return to IDLE, so they drive the bus directly.
    assign bus.m_request = m_request_q;
    assign bus.m_write   = hold_q.write;
    assign bus.m_address = hold_q.address;
    assign bus.m_data    = hold_q.data;
    assign bus.m_sel     = hold_q.sel;
    assign bus.req_grant = grant_q;
    assign bus.req_ready = ready_q;
    assign bus.req_error = error_q;
    assign bus.req_rdata = rdata_q;

endmodule

// File: tb/tb_buslayer_arbiter.sv
// Self-checking bench for buslayer_arbiter: directed scenarios plus randomized
// traffic against a round-robin reference model.
module tb_buslayer_arbiter;
    import buslayer_pkg::*;

    localparam int N = 4;

    logic wb_clk = 1'b0;
    logic wb_rst;
    always #5 wb_clk = ~wb_clk;

    buslayer_arbiter_if #(.NUM_REQ(N)) bus ();
    buslayer_arbiter #(.NUM_REQ(N)) dut (.wb_clk(wb_clk), .wb_rst(wb_rst), .bus(bus));

    int tests_run    = 0;
    int tests_failed = 0;
    int model_ptr    = 0;

    logic        f_wr   [N];
    logic [31:0] f_addr [N];
    logic [31:0] f_data [N];
    logic [3:0]  f_sel  [N];

    typedef struct {
        bit          timeout;
        bit          stable;
        bit          idle_zero;
        int          cycles;
        int          req_pulses;
        int          ready_pulses;
        int          error_pulses;
        logic [N-1:0] grant;
        logic [N-1:0] ready_vec;
        logic [N-1:0] error_vec;
        logic        write;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] rdata;
    } xfer_t;

    // Round-robin rule: the pending requester nearest at or after ptr, going upward with wrap.
    function automatic int rr_model(input logic [N-1:0] pend, input int ptr);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && ((i - ptr + N) % N) < bestd) begin
                best  = i;
                bestd = (i - ptr + N) % N;
            end
        end
        return best;
    endfunction

    task automatic drive_req(input int i, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        f_wr[i] = wr; f_addr[i] = a; f_data[i] = d; f_sel[i] = s;
        bus.req_write[i]   = wr;
        bus.req_address[i] = a;
        bus.req_data[i]    = d;
        bus.req_sel[i]     = s;
    endtask

    task automatic apply_reset();
        wb_rst = 1'b1;
        bus.req_request = '0;
        bus.m_busy = 1'b0; bus.m_ready = 1'b0; bus.m_error = 1'b0; bus.m_rdata = '0;
        @(negedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        model_ptr = 0;
    endtask

    // Bus-master responder and observer for one transfer, from IDLE back to IDLE.
    task automatic serve(input int refuse, input int waits, input bit rdy, input bit err,
                         input logic [31:0] rdata, input bit drop, output xfer_t x);
        int refuse_left = refuse;
        int cnt = 0;
        bit accepted = 0, responded = 0, resp_driven = 0, seen = 0, done = 0;
        x.timeout = 0; x.stable = 1; x.idle_zero = 0; x.cycles = 0;
        x.req_pulses = 0; x.ready_pulses = 0; x.error_pulses = 0;
        x.grant = '0; x.ready_vec = '0; x.error_vec = '0;
        x.write = 0; x.address = '0; x.data = '0; x.sel = '0; x.rdata = '0;
        bus.m_busy = 1'b0; bus.m_ready = 1'b0; bus.m_error = 1'b0; bus.m_rdata = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge wb_clk);
            x.cycles++;
            if (bus.req_grant != '0) begin
                if (!seen) begin
                    seen = 1;
                    x.grant = bus.req_grant; x.write = bus.m_write; x.address = bus.m_address;
                    x.data = bus.m_data; x.sel = bus.m_sel;
                end else if (bus.req_grant != x.grant || bus.m_write != x.write ||
                             bus.m_address != x.address || bus.m_data != x.data || bus.m_sel != x.sel) begin
                    x.stable = 0;
                end
            end
            if (bus.m_request) x.req_pulses++;
            if (|bus.req_ready) begin x.ready_pulses++; x.ready_vec = bus.req_ready; x.rdata = bus.req_rdata; end
            if (|bus.req_error) begin x.error_pulses++; x.error_vec = bus.req_error; end
            if (seen && bus.req_grant == '0) begin
                x.idle_zero = (bus.m_request == 0 && bus.m_write == 0 && bus.m_address == 0 &&
                               bus.m_data == 0 && bus.m_sel == 0 && bus.req_rdata == 0 &&
                               bus.req_ready == 0 && bus.req_error == 0);
                done = 1;
                break;
            end
            if (resp_driven) begin
                bus.m_ready = 1'b0; bus.m_error = 1'b0; bus.m_rdata = '0; bus.m_busy = 1'b0;
                resp_driven = 0;
            end else if (bus.m_request) begin
                if (drop) bus.req_request = bus.req_request & ~bus.req_grant;
                if (refuse_left > 0) begin
                    refuse_left--;
                    bus.m_busy = 1'b0;
                end else begin
                    bus.m_busy = 1'b1;
                    accepted = 1;
                    cnt = 0;
                end
            end else if (accepted && !responded) begin
                cnt++;
                if (cnt == waits + 1) begin
                    bus.m_ready = rdy; bus.m_error = err; bus.m_rdata = rdata;
                    responded = 1; resp_driven = 1;
                end
            end
        end
        if (!done) x.timeout = 1;
    endtask

    task automatic test_reset();
        xfer_t x;
        int w;
        @(negedge wb_clk);
        tests_run++;
        if ({bus.req_grant, bus.req_ready, bus.req_error, bus.req_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_req_outputs: got grant=%b ready=%b error=%b rdata=%h want all zero",
                     bus.req_grant, bus.req_ready, bus.req_error, bus.req_rdata);
        end
        tests_run++;
        if ({bus.m_request, bus.m_write, bus.m_address, bus.m_data, bus.m_sel} !== '0) begin
            tests_failed++;
            $display("FAIL reset_m_outputs: got req=%b wr=%b addr=%h data=%h sel=%h want all zero",
                     bus.m_request, bus.m_write, bus.m_address, bus.m_data, bus.m_sel);
        end
        // Release with the master still busy: nothing may be issued.
        drive_req(0, 1'b0, 32'h40, 32'h0, 4'hF);
        bus.req_request = 4'b0001;
        bus.m_busy = 1'b1;
        wb_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge wb_clk);
            tests_run++;
            if (bus.req_grant !== '0 || bus.m_request !== 1'b0) begin
                tests_failed++;
                $display("FAIL busy_after_reset: got grant=%b m_request=%b want 0/0", bus.req_grant, bus.m_request);
            end
        end
        w = rr_model(4'b0001, model_ptr);
        serve(0, 1, 1, 0, 32'h0BAD_F00D, 0, x);
        bus.req_request = '0;
        tests_run++;
        if (x.timeout || x.grant !== (N'(1) << w) || x.ready_pulses != 1) begin
            tests_failed++;
            $display("FAIL first_after_busy: got timeout=%0d grant=%b ready_pulses=%0d want 0/%b/1",
                     x.timeout, x.grant, x.ready_pulses, N'(1) << w);
        end
        model_ptr = (w + 1) % N;
    endtask

    task automatic test_single_read();
        xfer_t x;
        int w;
        drive_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
        bus.req_request = 4'b0001;
        w = rr_model(4'b0001, model_ptr);
        serve(0, 3, 1, 0, 32'hDEAD_BEEF, 0, x);
        bus.req_request = '0;
        model_ptr = (w + 1) % N;
        tests_run++;
        if (x.timeout || x.grant !== (N'(1) << w) || x.req_pulses != 1) begin
            tests_failed++;
            $display("FAIL single_read_issue: got timeout=%0d grant=%b m_request pulses=%0d want 0/%b/1",
                     x.timeout, x.grant, x.req_pulses, N'(1) << w);
        end
        tests_run++;
        if (x.ready_pulses != 1 || x.ready_vec !== 4'b0001 || x.error_pulses != 0 || x.rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_read_resp: got pulses=%0d vec=%b err=%0d rdata=%h want 1/0001/0/deadbeef",
                     x.ready_pulses, x.ready_vec, x.error_pulses, x.rdata);
        end
        tests_run++;
        if (x.address !== 32'h100 || x.write !== 1'b0 || !x.stable || !x.idle_zero || x.cycles != 7) begin
            tests_failed++;
            $display("FAIL single_read_bus: got addr=%h wr=%b stable=%0d idle_zero=%0d cycles=%0d want 100/0/1/1/7",
                     x.address, x.write, x.stable, x.idle_zero, x.cycles);
        end
    endtask

    task automatic test_refusal();
        xfer_t x;
        int w;
        logic [31:0] rd = $urandom;
        drive_req(1, 1'b1, $urandom, $urandom, 4'($urandom));
        bus.req_request = 4'b0010;
        w = rr_model(4'b0010, model_ptr);
        serve(2, 2, 1, 0, rd, 0, x);
        bus.req_request = '0;
        model_ptr = (w + 1) % N;
        tests_run++;
        if (x.timeout || x.req_pulses != 3 || x.ready_pulses != 1 || x.error_pulses != 0) begin
            tests_failed++;
            $display("FAIL refusal_pulses: got timeout=%0d m_request=%0d ready=%0d error=%0d want 0/3/1/0",
                     x.timeout, x.req_pulses, x.ready_pulses, x.error_pulses);
        end
        tests_run++;
        if (x.grant !== (N'(1) << w) || x.address !== f_addr[1] || x.data !== f_data[1] ||
            x.sel !== f_sel[1] || x.write !== 1'b1 || !x.stable || x.cycles != 10) begin
            tests_failed++;
            $display("FAIL refusal_fields: got grant=%b addr=%h data=%h sel=%h stable=%0d cycles=%0d want %b/%h/%h/%h/1/10",
                     x.grant, x.address, x.data, x.sel, x.stable, x.cycles, N'(1) << w, f_addr[1], f_data[1], f_sel[1]);
        end
    endtask

    task automatic test_error();
        xfer_t x;
        int w;
        drive_req(2, 1'b1, 32'h200, 32'h1234_5678, 4'hF);
        bus.req_request = 4'b0100;
        w = rr_model(4'b0100, model_ptr);
        serve(0, 2, 0, 1, 32'h0, 0, x);
        bus.req_request = '0;
        model_ptr = (w + 1) % N;
        tests_run++;
        if (x.timeout || x.error_pulses != 1 || x.error_vec !== (N'(1) << w) || x.ready_pulses != 0) begin
            tests_failed++;
            $display("FAIL error_resp: got timeout=%0d err_pulses=%0d err_vec=%b ready_pulses=%0d want 0/1/%b/0",
                     x.timeout, x.error_pulses, x.error_vec, x.ready_pulses, N'(1) << w);
        end
        tests_run++;
        if (x.address !== 32'h200 || x.data !== 32'h1234_5678 || x.sel !== 4'hF || x.write !== 1'b1 ||
            !x.stable || !x.idle_zero) begin
            tests_failed++;
            $display("FAIL error_fields: got addr=%h data=%h sel=%h wr=%b stable=%0d idle_zero=%0d want 200/12345678/f/1/1/1",
                     x.address, x.data, x.sel, x.write, x.stable, x.idle_zero);
        end
    endtask

    task automatic test_both_responses();
        xfer_t x;
        int w;
        logic [31:0] rd = $urandom;
        drive_req(3, 1'b0, $urandom, $urandom, 4'($urandom));
        bus.req_request = 4'b1000;
        w = rr_model(4'b1000, model_ptr);
        serve(1, 1, 1, 1, rd, 0, x);
        bus.req_request = '0;
        model_ptr = (w + 1) % N;
        tests_run++;
        if (x.timeout || x.ready_vec !== 4'b1000 || x.error_vec !== 4'b1000 ||
            x.ready_pulses != 1 || x.error_pulses != 1 || x.rdata !== rd) begin
            tests_failed++;
            $display("FAIL both_resp: got ready=%b/%0d error=%b/%0d rdata=%h want 1000/1 1000/1 %h",
                     x.ready_vec, x.ready_pulses, x.error_vec, x.error_pulses, x.rdata, rd);
        end
    endtask

    task automatic test_reset_in_wait();
        xfer_t x;
        int w;
        bit got = 0;
        apply_reset();
        drive_req(0, 1'b0, $urandom, $urandom, 4'hF);
        bus.req_request = 4'b0001;
        serve(0, 1, 1, 0, $urandom, 0, x);
        bus.req_request = '0;
        drive_req(1, 1'b1, $urandom, $urandom, 4'($urandom));
        bus.req_request = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(negedge wb_clk);
            if (bus.m_request) begin got = 1; break; end
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL reset_wait_issue: got no m_request within 20 cycles want one");
        end
        bus.m_busy = 1'b1;
        @(negedge wb_clk);
        @(negedge wb_clk);
        tests_run++;
        if (bus.req_grant !== 4'b0010) begin
            tests_failed++;
            $display("FAIL reset_wait_owner: got grant=%b want 0010", bus.req_grant);
        end
        #1 wb_rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.req_grant, bus.req_ready, bus.req_error, bus.req_rdata, bus.m_request,
             bus.m_write, bus.m_address, bus.m_data, bus.m_sel} !== '0) begin
            tests_failed++;
            $display("FAIL reset_wait_clear: got grant=%b m_request=%b addr=%h data=%h want all zero",
                     bus.req_grant, bus.m_request, bus.m_address, bus.m_data);
        end
        bus.req_request = '0;
        bus.m_ready = 1'b1; bus.m_error = 1'b1; bus.m_rdata = $urandom;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge wb_clk);
            bus.m_ready = 1'b0; bus.m_error = 1'b0;
            tests_run++;
            if (bus.req_ready !== '0 || bus.req_error !== '0 || bus.req_grant !== '0) begin
                tests_failed++;
                $display("FAIL reset_wait_no_pulse: got ready=%b error=%b grant=%b want 0/0/0",
                         bus.req_ready, bus.req_error, bus.req_grant);
            end
        end
        bus.m_busy = 1'b0;
        model_ptr = 0;
        bus.req_request = 4'b0011;
        w = rr_model(4'b0011, model_ptr);
        serve(0, 1, 1, 0, $urandom, 0, x);
        bus.req_request = '0;
        model_ptr = (w + 1) % N;
        tests_run++;
        if (x.timeout || x.grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_wait_ptr: got timeout=%0d grant=%b want 0/0001", x.timeout, x.grant);
        end
    endtask

    task automatic test_contention();
        xfer_t x;
        int w;
        logic [31:0] rd;
        apply_reset();
        drive_req(0, 1'b0, $urandom, $urandom, 4'($urandom));
        drive_req(1, 1'b1, $urandom, $urandom, 4'($urandom));
        bus.req_request = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            rd = $urandom;
            w = rr_model(4'b0011, model_ptr);
            serve(0, $urandom_range(1, 3), 1, 0, rd, 0, x);
            model_ptr = (w + 1) % N;
            tests_run++;
            if (x.timeout || x.grant !== (N'(1) << (t % 2)) || x.ready_vec !== x.grant ||
                x.rdata !== rd || x.cycles < 5 || x.address !== f_addr[t % 2]) begin
                tests_failed++;
                $display("FAIL contention_%0d: got grant=%b ready=%b rdata=%h cycles=%0d want grant %b rdata %h cycles>=5",
                         t, x.grant, x.ready_vec, x.rdata, x.cycles, N'(1) << (t % 2), rd);
            end
        end
        bus.req_request = '0;
    endtask

    task automatic test_wrap();
        xfer_t x;
        int w;
        drive_req(3, 1'b0, $urandom, $urandom, 4'($urandom));
        bus.req_request = 4'b1000;
        w = rr_model(4'b1000, model_ptr);
        serve(0, 1, 1, 0, $urandom, 0, x);
        model_ptr = (w + 1) % N;
        tests_run++;
        if (x.timeout || x.grant !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wrap_req3: got timeout=%0d grant=%b want 0/1000", x.timeout, x.grant);
        end
        drive_req(0, 1'b1, $urandom, $urandom, 4'($urandom));
        drive_req(2, 1'b0, $urandom, $urandom, 4'($urandom));
        bus.req_request = 4'b0101;
        w = rr_model(4'b0101, model_ptr);
        serve(0, 1, 1, 0, $urandom, 0, x);
        bus.req_request = '0;
        model_ptr = (w + 1) % N;
        tests_run++;
        if (x.timeout || x.grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL wrap_next: got timeout=%0d grant=%b want 0/0001", x.timeout, x.grant);
        end
    endtask

    task automatic test_random();
        xfer_t x;
        int w, refuse, waits, kind;
        bit drop;
        logic [31:0] rd;
        logic [N-1:0] pend = '0;
        int age [N];
        for (int i = 0; i < N; i++) age[i] = 0;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1; age[i] = 0;
                    drive_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom));
                end
            end
            if (pend == '0) begin
                pend[0] = 1'b1; age[0] = 0;
                drive_req(0, 1'($urandom), $urandom, $urandom, 4'($urandom));
            end
            bus.req_request = pend;
            w      = rr_model(pend, model_ptr);
            refuse = $urandom_range(0, 2);
            waits  = $urandom_range(1, 4);
            kind   = $urandom_range(0, 2);
            drop   = 1'($urandom);
            rd     = $urandom;
            serve(refuse, waits, kind != 1, kind != 0, rd, drop, x);
            tests_run++;
            if (x.timeout || x.grant !== (N'(1) << w) || x.req_pulses != refuse + 1 ||
                x.cycles != 2 * refuse + waits + 4) begin
                tests_failed++;
                $display("FAIL random_%0d_arb: got timeout=%0d grant=%b pulses=%0d cycles=%0d want 0/%b/%0d/%0d",
                         t, x.timeout, x.grant, x.req_pulses, x.cycles, N'(1) << w, refuse + 1, 2 * refuse + waits + 4);
            end
            tests_run++;
            if (x.write !== f_wr[w] || x.address !== f_addr[w] || x.data !== f_data[w] ||
                x.sel !== f_sel[w] || !x.stable || !x.idle_zero) begin
                tests_failed++;
                $display("FAIL random_%0d_fields: got wr=%b addr=%h data=%h sel=%h stable=%0d idle_zero=%0d want %b/%h/%h/%h/1/1",
                         t, x.write, x.address, x.data, x.sel, x.stable, x.idle_zero, f_wr[w], f_addr[w], f_data[w], f_sel[w]);
            end
            tests_run++;
            if (x.ready_pulses != ((kind != 1) ? 1 : 0) || x.error_pulses != ((kind != 0) ? 1 : 0) ||
                (kind != 1 && (x.ready_vec !== (N'(1) << w) || x.rdata !== rd)) ||
                (kind != 0 && x.error_vec !== (N'(1) << w))) begin
                tests_failed++;
                $display("FAIL random_%0d_resp: got ready=%b/%0d error=%b/%0d rdata=%h want kind=%0d owner=%0d rdata %h",
                         t, x.ready_vec, x.ready_pulses, x.error_vec, x.error_pulses, x.rdata, kind, w, rd);
            end
            tests_run++;
            if (age[w] > N - 1) begin
                tests_failed++;
                $display("FAIL random_%0d_starve: got requester %0d waited %0d transfers want at most %0d",
                         t, w, age[w], N - 1);
            end
            for (int i = 0; i < N; i++) if (pend[i] && i != w) age[i]++;
            pend[w] = 1'b0;
            bus.req_request = pend;
            model_ptr = (w + 1) % N;
        end
        bus.req_request = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rst = 1'b1;
        bus.req_request = '0; bus.req_write = '0; bus.req_address = '0;
        bus.req_data = '0; bus.req_sel = '0;
        bus.m_busy = 1'b0; bus.m_ready = 1'b0; bus.m_error = 1'b0; bus.m_rdata = '0;
        test_reset();
        test_single_read();
        test_refusal();
        test_error();
        test_both_responses();
        test_reset_in_wait();
        test_contention();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
